output_port_scheduler: RTL and testbench

//  Sequential scheduler for one router output port shared by four input requesters.

---
 rtl/router_pkg.sv | 17 +
 rtl/output_port_scheduler_rr_pick.sv | 26 ++
 rtl/output_port_scheduler.sv | 125 ++++++++++++
 tb/tb_output_port_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: requester count, scheduler state codes and the
// one-hot priority rotation helper used by the output-port scheduler and the
// round-robin picker.
package router_pkg;

    localparam int NUM_REQ = 4;

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_LOCKED = 1'b1;

    // Next requester in service order one->two->three->four->one. Requester
    // one sits in the MSB, so this is a rotate right by one position.
    function automatic logic [NUM_REQ-1:0] rotate_next(input logic [NUM_REQ-1:0] onehot);
        return {onehot[0], onehot[NUM_REQ-1:1]};
    endfunction

endpackage

// File: rtl/output_port_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// the one-hot priority pointer, in service order one->two->three->four.
// Zero when nothing requests. Reusable by the input-side arbiters.
module rr_pick
    import router_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] prio,
    output logic [NUM_REQ-1:0] winner
);

    logic [NUM_REQ-1:0] cand;

    // Walk the candidate pointer from prio and keep the first one that requests.
    always_comb begin
        winner = '0;
        cand   = prio;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == '0 && (cand & req) != '0) begin
                winner = cand;
            end
            cand = rotate_next(cand);
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Output-port scheduler for four requesters sharing one router output link.
// Grants are locked for the duration of a packet, priority rotates after
// contended packets, and downstream credits gate every transfer.
// Optional build macro SCHED_STATS_EN adds pkt_count and stall_count outputs.
// Handshake: a flit moves in a cycle exactly when grant[i] & req[i]; grant is
// never raised for an idle requester, so flit_valid = |grant marks transfers.
module output_port_scheduler
    import router_pkg::*;
#(
    parameter int CREDITS = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               credit_ret,
    output logic [NUM_REQ-1:0] grant,
    output logic               flit_valid,
    output logic [NUM_REQ-1:0] prio,
    output logic [CNT_W-1:0]   credits,
    output logic               isfull,
    output logic               locked,
    output logic               credit_err
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]        pkt_count,
    output logic [15:0]        stall_count
`endif
);

    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

    logic               state;
    logic               state_nxt;
    logic [NUM_REQ-1:0] owner;
    logic               contended;
    logic [NUM_REQ-1:0] pick;
    logic               multi_req;
    logic               tail;

    rr_pick u_rr_pick (
        .req    (req),
        .prio   (prio),
        .winner (pick)
    );

    assign multi_req  = (req & (req - 1'b1)) != '0;
    assign flit_valid = |grant;
    assign tail       = |(grant & last);
    assign isfull     = credits == '0;
    assign locked     = state == S_LOCKED;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: a non-tail winner opens a lock, the owner's tail releases it.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (flit_valid && !tail) state_nxt = S_LOCKED;
            S_LOCKED: if (tail) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Grant: arbitrate when idle, serve only the owner when locked; stall on no credit.
    always_comb begin
        grant = '0;
        if (!isfull) begin
            if (state == S_IDLE) grant = pick;
            else                 grant = owner & req;
        end
    end

    // Owner and contention flag are captured when a multi-flit packet starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= '0;
            contended <= 1'b0;
        end else if (state == S_IDLE && flit_valid && !tail) begin
            owner     <= grant;
            contended <= multi_req;
        end
    end

    // Priority moves past the winner on the tail of a contended packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 4'b1000;
        end else if (tail && ((state == S_IDLE) ? multi_req : contended)) begin
            prio <= rotate_next(grant);
        end
    end

    // Credit counter; a return into a full counter is flagged and dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits    <= CRED_MAX;
            credit_err <= 1'b0;
        end else if (flit_valid && !credit_ret) begin
            credits <= credits - 1'b1;
        end else if (!flit_valid && credit_ret) begin
            if (credits == CRED_MAX) credit_err <= 1'b1;
            else                     credits    <= credits + 1'b1;
        end
    end

`ifdef SCHED_STATS_EN
    // Saturating counters of completed packets and credit-starved request cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (tail && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 1'b1;
            if (req != '0 && isfull && stall_count != 16'hFFFF) stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// requester-index model of arbitration, locking, priority and credits.
module tb_output_port_scheduler;

    localparam int CREDITS = 8;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = '0;
    logic [3:0]       last = '0;
    logic             credit_ret = 1'b0;
    logic [3:0]       grant;
    logic             flit_valid;
    logic [3:0]       prio;
    logic [CNT_W-1:0] credits;
    logic             isfull;
    logic             locked;
    logic             credit_err;
`ifdef SCHED_STATS_EN
    logic [15:0]      pkt_count;
    logic [15:0]      stall_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    // Model state, in requester indices: 0=one, 1=two, 2=three, 3=four.
    int m_locked, m_owner, m_prio, m_cred, m_err, m_cont, m_pkt, m_stall;

    output_port_scheduler #(.CREDITS(CREDITS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .last       (last),
        .credit_ret (credit_ret),
        .grant      (grant),
        .flit_valid (flit_valid),
        .prio       (prio),
        .credits    (credits),
        .isfull     (isfull),
        .locked     (locked),
        .credit_err (credit_err)
`ifdef SCHED_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .stall_count(stall_count)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_prio = 0; m_cred = CREDITS;
        m_err = 0; m_cont = 0; m_pkt = 0; m_stall = 0;
    endtask

    // Reference model + scoreboard: predict this cycle's outputs, compare,
    // then advance the model with the inputs the coming edge will sample.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            exp_q.delete();
        end else begin
            logic [3:0] eg;
            int w;
            bit xfer, is_tail;
            eg = '0;
            w = 0;
            if (m_cred > 0) begin
                if (m_locked == 0) begin
                    for (int k = 0; k < 4; k++) begin
                        int j;
                        j = (m_prio + k) % 4;
                        if (eg == '0 && req[3-j]) begin
                            eg[3-j] = 1'b1;
                            w = j;
                        end
                    end
                end else if (req[3-m_owner]) begin
                    eg[3-m_owner] = 1'b1;
                    w = m_owner;
                end
            end
            exp_q.push_back(eg);

            chk("grant", grant, exp_q.pop_front());
            chk("flit_valid", flit_valid, (eg != '0));
            chk("prio", prio, 32'(1) << (3 - m_prio));
            chk("credits", credits, m_cred);
            chk("isfull", isfull, (m_cred == 0));
            chk("locked", locked, m_locked);
            chk("credit_err", credit_err, m_err);
`ifdef SCHED_STATS_EN
            chk("pkt_count", pkt_count, m_pkt);
            chk("stall_count", stall_count, m_stall);
`endif

            xfer    = (eg != '0);
            is_tail = xfer && last[3-w];
            if (req != '0 && m_cred == 0 && m_stall < 65535) m_stall++;
            if (is_tail && m_pkt < 65535) m_pkt++;
            if (m_locked == 0 && xfer) begin
                if (is_tail) begin
                    if ($countones(req) > 1) m_prio = (w + 1) % 4;
                end else begin
                    m_locked = 1;
                    m_owner  = w;
                    m_cont   = ($countones(req) > 1);
                end
            end else if (m_locked == 1 && is_tail) begin
                if (m_cont != 0) m_prio = (w + 1) % 4;
                m_locked = 0;
            end
            if (xfer && !credit_ret) m_cred--;
            else if (!xfer && credit_ret) begin
                if (m_cred == CREDITS) m_err = 1;
                else m_cred++;
            end
        end
    end

    // Driver: change inputs just after the edge, return at the following
    // falling edge so the caller can sample the combinational outputs.
    task automatic apply(input logic [3:0] r, input logic [3:0] l, input logic c);
        @(posedge clk);
        #1;
        req = r; last = l; credit_ret = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; req = '0; last = '0; credit_ret = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset state and a single-flit uncontended packet.
        @(negedge clk);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_flit_valid", flit_valid, 1'b0);
        chk("rst_prio", prio, 4'b1000);
        chk("rst_credits", credits, 8);
        chk("rst_isfull", isfull, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_credit_err", credit_err, 1'b0);
        apply(4'b0100, 4'b0100, 1'b0);
        chk("t1_grant", grant, 4'b0100);
        apply(4'b0000, 4'b0000, 1'b0);
        chk("t1_credits", credits, 7);
        chk("t1_prio", prio, 4'b1000);

        // Contended 3-flit packet from one, then priority has moved to two.
        do_reset();
        apply(4'b1111, 4'b0000, 1'b0);
        chk("t2_grant0", grant, 4'b1000);
        chk("t2_locked0", locked, 1'b0);
        apply(4'b1111, 4'b0000, 1'b0);
        chk("t2_grant1", grant, 4'b1000);
        chk("t2_locked1", locked, 1'b1);
        apply(4'b1111, 4'b1000, 1'b0);
        chk("t2_grant2", grant, 4'b1000);
        chk("t2_locked2", locked, 1'b1);
        apply(4'b1111, 4'b1111, 1'b0);
        chk("t2_prio", prio, 4'b0100);
        chk("t2_next_grant", grant, 4'b0100);
        chk("t2_unlocked", locked, 1'b0);

        // Owner two bubbles for two cycles while three requests.
        do_reset();
        apply(4'b0100, 4'b0000, 1'b0);
        chk("t3_grant", grant, 4'b0100);
        apply(4'b0010, 4'b0000, 1'b0);
        chk("t3_bubble_grant0", grant, 4'b0000);
        chk("t3_bubble_locked0", locked, 1'b1);
        apply(4'b0010, 4'b0010, 1'b0);
        chk("t3_bubble_grant1", grant, 4'b0000);
        chk("t3_bubble_locked1", locked, 1'b1);
        apply(4'b0110, 4'b0100, 1'b0);
        chk("t3_tail_grant", grant, 4'b0100);
        apply(4'b0000, 4'b0000, 1'b0);
        chk("t3_unlocked", locked, 1'b0);
        chk("t3_prio", prio, 4'b1000);

        // Credits exhausted, then one return lets one flit through.
        do_reset();
        for (int i = 0; i < CREDITS; i++) apply(4'b1000, 4'b1000, 1'b0);
        apply(4'b1000, 4'b1000, 1'b0);
        chk("t4_isfull", isfull, 1'b1);
        chk("t4_stall_grant", grant, 4'b0000);
        apply(4'b1000, 4'b1000, 1'b1);
        chk("t4_ret_grant", grant, 4'b0000);
        apply(4'b1000, 4'b1000, 1'b0);
        chk("t4_resume_grant", grant, 4'b1000);
        chk("t4_resume_credits", credits, 1);

        // Flit and return together; return into a full counter.
        do_reset();
        for (int i = 0; i < 5; i++) apply(4'b1000, 4'b1000, 1'b0);
        apply(4'b1000, 4'b1000, 1'b1);
        chk("t5_both_credits_before", credits, 3);
        apply(4'b0000, 4'b0000, 1'b0);
        chk("t5_both_credits_after", credits, 3);
        do_reset();
        apply(4'b0000, 4'b0000, 1'b1);
        apply(4'b0000, 4'b0000, 1'b0);
        chk("t5_credit_err", credit_err, 1'b1);
        chk("t5_err_credits", credits, 8);

        // Asynchronous reset while locked mid-packet.
        do_reset();
        apply(4'b1000, 4'b1111, 1'b0);
        apply(4'b1000, 4'b0000, 1'b0);
        apply(4'b1000, 4'b0000, 1'b0);
        chk("t6_pre_locked", locked, 1'b1);
        #2;
        rst = 1'b1; req = '0; last = '0; credit_ret = 1'b0;
        #1;
        chk("t6_locked", locked, 1'b0);
        chk("t6_prio", prio, 4'b1000);
        chk("t6_credits", credits, 8);
`ifdef SCHED_STATS_EN
        chk("t6_pkt_count", pkt_count, 0);
`endif
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r, l;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 2) r = '0;
            l = '0;
            for (int b = 0; b < 4; b++) l[b] = ($urandom_range(0, 2) == 0);
            apply(r, l, ($urandom_range(0, 99) < 40));
        end

        apply(4'b0000, 4'b0000, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
